// File: rtl/cordic_sqrt_pkg.sv
// Shared definitions for the CORDIC square-root family: FSM states, default
// Q-format parameters and the round-half-up bias helper.
package cordic_sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } sqr_state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_OUT_F = 6;

   // Half of one LSB after dropping `shift` fraction bits (round-half-up bias).
   function automatic logic [63:0] half_lsb(input int unsigned shift);
      half_lsb = (shift == 0) ? 64'd0 : (64'd1 << (shift - 1));
   endfunction

endpackage

// File: rtl/sqr_shift_add_dp.sv
// Shift-add squaring datapath: multiplicand/multiplier/accumulator registers
// and the iteration counter that marks the final step.
module sqr_shift_add_dp
   import cordic_sqrt_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   root_in,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               last
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] a;
   logic [WIDTH-1:0]   b;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   // The accumulator cannot overflow: (2^WIDTH-1)^2 fits in 2*WIDTH bits.
   assign acc_next = b[0] ? (acc + a) : acc;
   assign last     = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a   <= '0;
         b   <= '0;
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         a   <= {{WIDTH{1'b0}}, root_in};
         b   <= root_in;
         acc <= '0;
         cnt <= '0;
      end else if (step) begin
         acc <= acc_next;
         a   <= a << 1;
         b   <= b >> 1;
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cordic_sqrt_squarer.sv
// Sequential squarer behind the CORDIC root pipeline: returns the exact square
// of a Q-format root plus the rounded, saturated integer it represents.
module cordic_sqrt_squarer
   import cordic_sqrt_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int OUT_F = DEF_OUT_F
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   root_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] sq_full,
   output logic [WIDTH-1:0]   n_out,
   output logic               sat
);

   localparam int SQ_W = 2 * WIDTH;
   localparam logic [SQ_W:0] RND = (SQ_W + 1)'(half_lsb(2 * OUT_F));

   // Returns {sat, n}: round-half-up of the square to an integer, clamped.
   function automatic logic [WIDTH:0] round_sat(input logic [SQ_W-1:0] sq);
      logic [SQ_W:0] r;
      r = ({1'b0, sq} + RND) >> (2 * OUT_F);
      if (|r[SQ_W:WIDTH]) round_sat = {1'b1, {WIDTH{1'b1}}};
      else                round_sat = {1'b0, r[WIDTH-1:0]};
   endfunction

   sqr_state_t        state, state_next;
   logic              load, step, last;
   logic [SQ_W-1:0]   acc_next;
   logic [WIDTH:0]    rs;

   sqr_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .root_in  (root_in),
      .acc_next (acc_next),
      .last     (last)
   );

   assign rs = round_sat(acc_next);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (in_valid)  state_next = BUSY;
         BUSY:    if (last)      state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            load     = in_valid;
         end
         BUSY:    step      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Results are captured on the final iteration edge and held through DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_full <= '0;
         n_out   <= '0;
         sat     <= 1'b0;
      end else if (step && last) begin
         sq_full      <= acc_next;
         {sat, n_out} <= rs;
      end
   end

endmodule

// File: tb/tb_cordic_sqrt_squarer.sv
// Testbench for cordic_sqrt_squarer: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_cordic_sqrt_squarer;

   localparam int W = 16;
   localparam int F = 6;
   localparam int LAT = W;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   root_in;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] sq_full;
   logic [W-1:0]   n_out;
   logic           sat;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cordic_sqrt_squarer #(.WIDTH(W), .OUT_F(F)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .root_in   (root_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sq_full   (sq_full),
      .n_out     (n_out),
      .sat       (sat)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer square, round-half-up, clamp.
   function automatic logic [63:0] ref_n(input logic [63:0] sq);
      logic [63:0] r;
      r = (sq + (64'd1 << (2*F - 1))) >> (2*F);
      return (r > 64'hFFFF) ? 64'hFFFF : r;
   endfunction

   // Transaction model: idle -> accept -> LAT edges busy -> result until taken.
   logic           m_busy, m_valid, m_sat;
   int             m_cnt;
   logic [W-1:0]   m_op;
   logic [2*W-1:0] m_sq;
   logic [W-1:0]   m_n;
   logic [63:0]    m_tmp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0;
         m_sq = '0; m_n = '0; m_sat = 1'b0; m_op = '0;
      end else if (m_valid) begin
         if (out_ready) m_valid = 1'b0;
      end else if (m_busy) begin
         m_cnt++;
         if (m_cnt == LAT) begin
            m_busy  = 1'b0;
            m_valid = 1'b1;
            m_tmp   = 64'(m_op) * 64'(m_op);
            m_sq    = m_tmp[2*W-1:0];
            m_n     = ref_n(m_tmp) & 64'hFFFF;
            m_sat   = (ref_n(m_tmp) == 64'hFFFF) && (m_tmp >= 64'hFFFF800);
         end
      end else if (in_valid) begin
         m_busy = 1'b1;
         m_cnt  = 0;
         m_op   = root_in;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("model_out_valid", out_valid, m_valid);
         chk("model_in_ready", in_ready, !m_busy && !m_valid);
         chk("model_sq_full", sq_full, m_sq);
         chk("model_n_out", n_out, m_n);
         chk("model_sat", sat, m_sat);
      end
   end

   task automatic run_op(input logic [W-1:0] root, input logic [63:0] e_sq,
                         input logic [63:0] e_n, input logic e_sat, input int hold);
      int lat;
      logic [2*W-1:0] sq_hold;
      @(negedge clk);
      root_in = root; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("accept_in_ready_low", in_ready, 1'b0);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, LAT);
      chk("lit_sq_full", sq_full, e_sq);
      chk("lit_n_out", n_out, e_n);
      chk("lit_sat", sat, e_sat);
      sq_hold = sq_full;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         root_in  = W'($urandom);
         @(negedge clk);
         chk("hold_out_valid", out_valid, 1'b1);
         chk("hold_in_ready", in_ready, 1'b0);
         chk("hold_sq_full", sq_full, sq_hold);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_out_valid", out_valid, 1'b0);
      chk("release_in_ready", in_ready, 1'b1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; root_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sq_full", sq_full, 0);
      chk("rst_n_out", n_out, 0);
      chk("rst_sat", sat, 1'b0);
      #2 rst_n = 1'b1;

      run_op(16'h0400, 64'h0010_0000, 64'd256, 1'b0, 0);
      run_op(16'h0080, 64'h0000_4000, 64'd4, 1'b0, 0);
      run_op(16'h0000, 64'd0, 64'd0, 1'b0, 0);
      run_op(16'h005B, 64'd8281, 64'd2, 1'b0, 0);
      run_op(16'h0071, 64'd12769, 64'd3, 1'b0, 5);
      run_op(16'hFFFF, 64'hFFFE_0001, 64'hFFFF, 1'b1, 5);

      // Reset after 7 iterations discards the operation.
      @(negedge clk);
      root_in = 16'h1234; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_sq_full", sq_full, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("midrst_no_pulse", out_valid, 1'b0);
      end
      run_op(16'h0080, 64'h0000_4000, 64'd4, 1'b0, 0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 2) == 0);
         out_ready = $urandom_range(0, 1);
         case ($urandom_range(0, 7))
            0:       root_in = 16'hFFFF;
            1:       root_in = 16'h0000;
            2:       root_in = W'($urandom_range(0, 16'h0FFF));
            default: root_in = W'($urandom);
         endcase
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (LAT + 4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
